// File: rtl/gift_pkg.sv
// ---------------------------------------------------------------------------
// gift_pkg
// Shared definitions for the GIFT-128 key-schedule blocks (encryption and
// decryption side).
//   - GIFT128_ROUNDS / GIFT_RC_INIT : round count and initial round constant
//   - GIFT_KW                       : key-word width (eight words per key)
//   - keysch_state_e                : key-schedule FSM state encoding
//   - gift_key_fwd / gift_key_inv   : one-round forward / inverse key update
//   - gift_rc_fwd  / gift_rc_inv    : one-round forward / inverse RC LFSR step
// Key layout: k7 = [127:112] ... k0 = [15:0].
// ---------------------------------------------------------------------------
package gift_pkg;

  localparam int         GIFT128_ROUNDS = 40;
  localparam logic [5:0] GIFT_RC_INIT   = 6'h01;
  localparam int         GIFT_KW        = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } keysch_state_e;

  // New k7 = k1 rotr 2, new k6 = k0 rotr 12, remaining words shift down by two.
  function automatic logic [127:0] gift_key_fwd(input logic [127:0] k);
    logic [GIFT_KW-1:0] k1;
    logic [GIFT_KW-1:0] k0;
    k1 = k[31:16];
    k0 = k[15:0];
    return {{k1[1:0], k1[15:2]}, {k0[11:0], k0[15:12]}, k[127:32]};
  endfunction

  // Exact inverse of gift_key_fwd: words shift up by two, the rotated pair
  // is rotated back into k1/k0.
  function automatic logic [127:0] gift_key_inv(input logic [127:0] k);
    logic [GIFT_KW-1:0] k7;
    logic [GIFT_KW-1:0] k6;
    k7 = k[127:112];
    k6 = k[111:96];
    return {k[95:0], {k7[13:0], k7[15:14]}, {k6[3:0], k6[15:4]}};
  endfunction

  function automatic logic [5:0] gift_rc_fwd(input logic [5:0] c);
    return {c[4:0], c[5] ^ c[4] ^ 1'b1};
  endfunction

  // The shifted-out bit c5 is recovered from the feedback bit n0 = c5^c4^1
  // with c4 = n5.
  function automatic logic [5:0] gift_rc_inv(input logic [5:0] n);
    return {n[0] ^ n[5] ^ 1'b1, n[5:1]};
  endfunction

endpackage

// File: rtl/gift_rc_lfsr.sv
// ---------------------------------------------------------------------------
// gift_rc_lfsr
// 6-bit GIFT round-constant LFSR with load / forward / inverse controls.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset, clears the constant to 0
//   load   : load RC_INIT (highest priority)
//   fwd    : one forward LFSR step
//   inv    : one inverse LFSR step (lowest priority)
//   rc     : current round constant (registered)
// ---------------------------------------------------------------------------
module gift_rc_lfsr
  import gift_pkg::*;
#(
  parameter logic [5:0] RC_INIT = GIFT_RC_INIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       fwd,
  input  logic       inv,
  output logic [5:0] rc
);

  logic [5:0] rc_d;
  logic [5:0] rc_q;

  always_comb begin
    rc_d = rc_q;
    if (load)     rc_d = RC_INIT;
    else if (fwd) rc_d = gift_rc_fwd(rc_q);
    else if (inv) rc_d = gift_rc_inv(rc_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rc_q <= 6'h00;
    else        rc_q <= rc_d;
  end

  assign rc = rc_q;

endmodule

// File: rtl/gift_enc_keysch_engine.sv
// ---------------------------------------------------------------------------
// gift_enc_keysch_engine
// Encryption-side GIFT-128 key schedule. Holds the 128-bit key state, the
// round constant and the round index, advancing one round per inStep.
// Optional macro GIFT_KEYSCH_INV_EN adds inStepBack (one inverse round).
// Ports:
//   inClk, inRstN      : clock / synchronous active-low reset
//   inExtWr, inExtData : load master key (RC <= RC_INIT, round <= 1)
//   inStep             : advance one round (ACTIVE only)
//   inStepBack         : step back one round (only with GIFT_KEYSCH_INV_EN)
//   outKeyValid        : key state holds a loaded/derived key
//   outRoundNum        : current round index
//   outExtRoundConst   : round constant for current round
//   outRoundKeyU/V     : k5||k4 and k1||k0 of the current key state
//   outExtData         : full key state
//   outDone            : current round is the last round
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module gift_enc_keysch_engine
  import gift_pkg::*;
#(
  parameter int         NUM_ROUNDS = GIFT128_ROUNDS,
  parameter logic [5:0] RC_INIT    = GIFT_RC_INIT
) (
  input  logic         inClk,
  input  logic         inRstN,
  input  logic         inExtWr,
  input  logic [127:0] inExtData,
  input  logic         inStep,
`ifdef GIFT_KEYSCH_INV_EN
  input  logic         inStepBack,
`endif
  output logic         outKeyValid,
  output logic [5:0]   outRoundNum,
  output logic [5:0]   outExtRoundConst,
  output logic [31:0]  outRoundKeyU,
  output logic [31:0]  outRoundKeyV,
  output logic [127:0] outExtData,
  output logic         outDone
);

  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS);

  keysch_state_e state_d, state_q;
  logic [127:0]  key_d, key_q;
  logic [5:0]    round_d, round_q;
  logic          rc_load, rc_fwd, rc_inv;
  logic          step_req, back_req;

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    round_d  = round_q;
    rc_load  = 1'b0;
    rc_fwd   = 1'b0;
    rc_inv   = 1'b0;
`ifdef GIFT_KEYSCH_INV_EN
    // Conflicting direction requests cancel each other.
    step_req = inStep & ~inStepBack;
    back_req = inStepBack & ~inStep;
`else
    step_req = inStep;
    back_req = 1'b0;
`endif
    if (inExtWr) begin
      key_d   = inExtData;
      round_d = 6'd1;
      rc_load = 1'b1;
      state_d = ST_ACTIVE;
    end else if (step_req && state_q == ST_ACTIVE && round_q < LAST_ROUND) begin
      key_d   = gift_key_fwd(key_q);
      round_d = round_q + 6'd1;
      rc_fwd  = 1'b1;
      if (round_q + 6'd1 == LAST_ROUND) state_d = ST_DONE;
    end else if (back_req && state_q != ST_IDLE && round_q > 6'd1) begin
      key_d   = gift_key_inv(key_q);
      round_d = round_q - 6'd1;
      rc_inv  = 1'b1;
      state_d = ST_ACTIVE;
    end
  end

  always_ff @(posedge inClk) begin
    if (!inRstN) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  gift_rc_lfsr #(
    .RC_INIT (RC_INIT)
  ) u_rc_lfsr (
    .clk   (inClk),
    .rst_n (inRstN),
    .load  (rc_load),
    .fwd   (rc_fwd),
    .inv   (rc_inv),
    .rc    (outExtRoundConst)
  );

  assign outKeyValid  = (state_q != ST_IDLE);
  assign outDone      = (state_q == ST_DONE);
  assign outRoundNum  = round_q;
  assign outRoundKeyU = key_q[95:64];
  assign outRoundKeyV = key_q[31:0];
  assign outExtData   = key_q;

endmodule

// File: tb/tb_gift_enc_keysch_engine.sv
module tb_gift_enc_keysch_engine;

  logic         clk;
  logic         rst_n;
  logic         wr;
  logic [127:0] data;
  logic         step;
  logic         back;
  logic         out_valid;
  logic [5:0]   out_round;
  logic [5:0]   out_rc;
  logic [31:0]  out_u;
  logic [31:0]  out_v;
  logic [127:0] out_data;
  logic         out_done;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  // Behavioural model: key as eight 16-bit words, plus RC, round, flags.
  logic [15:0] mk [8];
  logic [5:0]  m_rc;
  int          m_round;
  bit          m_valid;
  bit          m_done;

  gift_enc_keysch_engine dut (
    .inClk            (clk),
    .inRstN           (rst_n),
    .inExtWr          (wr),
    .inExtData        (data),
    .inStep           (step),
`ifdef GIFT_KEYSCH_INV_EN
    .inStepBack       (back),
`endif
    .outKeyValid      (out_valid),
    .outRoundNum      (out_round),
    .outExtRoundConst (out_rc),
    .outRoundKeyU     (out_u),
    .outRoundKeyV     (out_v),
    .outExtData       (out_data),
    .outDone          (out_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rotr16(input logic [15:0] x, input int n);
    return (x >> n) | (x << (16 - n));
  endfunction

  function automatic logic [127:0] model_key();
    logic [127:0] v;
    for (int i = 0; i < 8; i++) v[i*16 +: 16] = mk[i];
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the model advances with the same edge.
  task automatic cycle(input bit r, input bit w, input logic [127:0] d,
                       input bit s, input bit b);
    logic [15:0] old [8];
    rst_n = r; wr = w; data = d; step = s; back = b;
    @(posedge clk);
    for (int i = 0; i < 8; i++) old[i] = mk[i];
    if (!r) begin
      for (int i = 0; i < 8; i++) mk[i] = 16'h0;
      m_rc = 6'h00; m_round = 0; m_valid = 0; m_done = 0;
    end else if (w) begin
      for (int i = 0; i < 8; i++) mk[i] = d[i*16 +: 16];
      m_rc = 6'h01; m_round = 1; m_valid = 1; m_done = 0;
    end else if (s && !b && m_valid && !m_done) begin
      for (int i = 0; i < 6; i++) mk[i] = old[i+2];
      mk[7] = rotr16(old[1], 2);
      mk[6] = rotr16(old[0], 12);
      m_rc = {m_rc[4:0], m_rc[5] ^ m_rc[4] ^ 1'b1};
      m_round++;
      m_done = (m_round == 40);
    end else if (b && !s && m_valid && m_round > 1) begin
      for (int i = 2; i < 8; i++) mk[i] = old[i-2];
      mk[1] = rotr16(old[7], 14);
      mk[0] = rotr16(old[6], 4);
      m_rc = {m_rc[0] ^ m_rc[5] ^ 1'b1, m_rc[5:1]};
      m_round--;
      m_done = 0;
    end
    #1;
    $display("[TB] t=%0t rst_n=%0b wr=%0b step=%0b back=%0b -> round=%0d rc=%02h valid=%0b done=%0b",
             $time, r, w, s, b, m_round, m_rc, m_valid, m_done);
  endtask

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("valid", 128'(out_valid), 128'(m_valid));
      chk("done",  128'(out_done),  128'(m_done));
      chk("round", 128'(out_round), 128'(m_round));
      chk("rc",    128'(out_rc),    128'(m_rc));
      chk("key",   out_data,        model_key());
      chk("U",     128'(out_u),     128'({mk[5], mk[4]}));
      chk("V",     128'(out_v),     128'({mk[1], mk[0]}));
    end
  end

  logic [5:0]   rc_tab [6];
  logic [127:0] k2, k3, kr;

  initial begin
    rc_tab = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E};
    k2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    k3 = 128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_1357_9BDF;
    for (int i = 0; i < 8; i++) mk[i] = 16'h0;
    m_rc = 0; m_round = 0; m_valid = 0; m_done = 0;
    rst_n = 0; wr = 0; data = '0; step = 0; back = 0;

    // Reset, release, step while idle.
    cycle(0, 0, '0, 0, 0);
    check_en = 1'b1;
    cycle(0, 0, '0, 0, 0);
    cycle(1, 0, '0, 0, 0);
    cycle(1, 0, '0, 1, 0);
    chk("idle_valid", 128'(out_valid), 128'(0));
    chk("idle_rc",    128'(out_rc),    128'(0));
    chk("idle_round", 128'(out_round), 128'(0));
    chk("idle_key",   out_data,        128'(0));

    // Load k0=1, then one step.
    cycle(1, 1, 128'h1, 0, 0);
    chk("ld_rc",    128'(out_rc),    128'h01);
    chk("ld_round", 128'(out_round), 128'd1);
    chk("ld_V",     128'(out_v),     128'h0000_0001);
    cycle(1, 0, '0, 1, 0);
    chk("st_k6",    128'(out_data[111:96]), 128'h0010);
    chk("st_k0",    128'(out_data[15:0]),   128'h0000);
    chk("st_rc",    128'(out_rc),    128'h03);
    chk("st_round", 128'(out_round), 128'd2);

    // RC sequence and run to the last round.
    cycle(1, 1, k2, 0, 0);
    chk("rcseq0", 128'(out_rc), 128'(rc_tab[0]));
    for (int i = 1; i < 6; i++) begin
      cycle(1, 0, '0, 1, 0);
      chk($sformatf("rcseq%0d", i), 128'(out_rc), 128'(rc_tab[i]));
    end
    for (int i = 0; i < 34; i++) cycle(1, 0, '0, 1, 0);
    chk("last_rc",    128'(out_rc),    128'h1A);
    chk("last_round", 128'(out_round), 128'd40);
    chk("last_done",  128'(out_done),  128'd1);
    cycle(1, 0, '0, 1, 0);
    chk("sat_rc",    128'(out_rc),    128'h1A);
    chk("sat_round", 128'(out_round), 128'd40);

    // Reload from DONE, run to round 12, then load+step together.
    cycle(1, 1, k2, 0, 0);
    chk("reld_done", 128'(out_done), 128'd0);
    for (int i = 0; i < 11; i++) cycle(1, 0, '0, 1, 0);
    chk("r12_round", 128'(out_round), 128'd12);
    cycle(1, 1, k3, 1, 0);
    chk("wrst_round", 128'(out_round), 128'd1);
    chk("wrst_rc",    128'(out_rc),    128'h01);
    chk("wrst_key",   out_data,        k3);

    // Mid-run reset.
    for (int i = 0; i < 3; i++) cycle(1, 0, '0, 1, 0);
    cycle(0, 0, '0, 1, 0);
    chk("rst_valid", 128'(out_valid), 128'd0);
    chk("rst_rc",    128'(out_rc),    128'd0);
    chk("rst_round", 128'(out_round), 128'd0);
    chk("rst_key",   out_data,        128'd0);
    cycle(1, 0, '0, 1, 0);
    chk("rst_idle_round", 128'(out_round), 128'd0);

`ifdef GIFT_KEYSCH_INV_EN
    kr = {$urandom, $urandom, $urandom, $urandom};
    cycle(1, 1, kr, 0, 0);
    for (int i = 0; i < 39; i++) cycle(1, 0, '0, 1, 0);
    cycle(1, 0, '0, 1, 1);
    chk("both_round", 128'(out_round), 128'd40);
    for (int i = 0; i < 39; i++) cycle(1, 0, '0, 0, 1);
    chk("inv_key",   out_data,        kr);
    chk("inv_rc",    128'(out_rc),    128'h01);
    chk("inv_round", 128'(out_round), 128'd1);
    cycle(1, 0, '0, 0, 1);
    chk("inv_floor", 128'(out_round), 128'd1);
    chk("inv_floor_key", out_data, kr);
`else
    kr = '0;
`endif

    cycle(1, 0, '0, 0, 0);
    @(negedge clk);
    #1;
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gift_enc_keysch_engine.md
Name: gift_enc_keysch_engine

Overview:
- Encryption-side GIFT-128 key-schedule engine; counterpart of the decryption key-schedule register.
- Loads the 128-bit master key with round constant 0x01 and round number 1.
- Advances key state and the 6-bit round-constant LFSR one round per step request, through round 40.
- Supplies per-round U/V round-key words and the round constant to the one-round encryption datapath.

Parameters:
- NUM_ROUNDS, 40, last round index; step requests beyond it are ignored.
- RC_INIT, 6'h01, round constant loaded with the key.

Ports:
- inClk  input  1  clock, all state updates on rising edge
- inRstN  input  1  synchronous active-low reset
- inExtWr  input  1  load strobe: capture inExtData as the master key
- inExtData  input  128  master key; k7 = [127:112] … k0 = [15:0]
- inStep  input  1  advance one round
- outKeyValid  output  1  key state holds a loaded/derived key
- outRoundNum  output  6  current round index, 1..NUM_ROUNDS
- outExtRoundConst  output  6  round constant for current round
- outRoundKeyU  output  32  k5||k4 of current state
- outRoundKeyV  output  32  k1||k0 of current state
- outExtData  output  128  full key state
- outDone  output  1  current round == NUM_ROUNDS

Behaviour:
- Reset: synchronous active-low, sampled on inClk rising edge while inRstN=0, and overrides all other inputs.
  - Key state 0, RC 0, round 0, FSM IDLE.
  - outKeyValid=0, outDone=0.
  - U/V and outExtData read as 0.
- FSM states:
  - IDLE: after reset. inExtWr -> ACTIVE. inStep ignored.
  - ACTIVE: inStep -> one forward update. Reaching round NUM_ROUNDS -> DONE.
  - DONE: inStep ignored, state held. inExtWr -> ACTIVE.
- Load: inExtWr=1 in any state:
  - key <= inExtData, RC <= RC_INIT, round <= 1, FSM -> ACTIVE.
  - Load has priority over a simultaneous inStep.
- Forward key update, new from old:
  - k7=k1>>>2, k6=k0>>>12 (16-bit rotates).
  - k5=k7, k4=k6, k3=k5, k2=k4, k1=k3, k0=k2.
- RC LFSR update: (c5..c0) <= (c4,c3,c2,c1,c0, c5^c4^1).
- Round counter: +1 per accepted step; saturates at NUM_ROUNDS.
- Latency: all outputs are registered. A step or load accepted at edge N is visible after edge N; there are no combinational paths from inputs to outputs.
- outKeyValid=1 in ACTIVE and DONE; outDone=1 only in DONE.

Optional Feature:
- Macro: GIFT_KEYSCH_INV_EN.
- When defined: adds input inStepBack (1 bit), applying one inverse update.
  - Key inverse: k7=k5', k6=k4', k5=k3', k4=k2', k3=k1', k2=k0', k1=k7'<<<2, k0=k6'<<<12.
  - RC inverse: c4..c0 = n5..n1, c5 = n0^n5^1.
  - Round -1; valid in ACTIVE or DONE while round > 1; DONE -> ACTIVE.
  - At round 1 the request is ignored.
  - inStep and inStepBack together: neither applied.
  - inExtWr beats both.
- When undefined: port absent, forward-only engine.

Decomposition:
- Shared package gift_pkg:
  - constants GIFT128_ROUNDS=40, GIFT_RC_INIT=6'h01;
  - key-word width 16;
  - FSM state encoding (IDLE/ACTIVE/DONE);
  - functions for forward/inverse key update and RC update, reused by the decryption key schedule.
- One natural sub-module: gift_rc_lfsr (6-bit round-constant LFSR with load/forward/inverse controls).

Test Plan:
- Reset then idle: inRstN=0 for 2 cycles, release, pulse inStep -> outKeyValid=0, RC=0x00, round=0, outExtData=0.
- Load key 0x0000…0001 (k0=0x0001) -> RC=0x01, round=1, V=0x00000001; one inStep -> k6=0x0010, k0=0, RC=0x03, round=2.
- Load any key, 5 steps -> RC sequence 01,03,07,0F,1F,3E; after 39 steps -> RC=0x1A, round=40, outDone=1; extra inStep -> no change.
- inExtWr and inStep same cycle at round 12 -> round=1, RC=0x01, key=inExtData; mid-run inRstN=0 -> all outputs 0, FSM IDLE.
- GIFT_KEYSCH_INV_EN: load random key, 39 steps, 39 inStepBack -> outExtData equals loaded key, RC=0x01, round=1; further inStepBack ignored.
